// File: rtl/rs_chien_ctrl.sv
// Chien-search job sequencer: launches the root generator, counts per-lane locator
// zeros over a full search, streams the pad-masked position beats and reports the verdict.
module rs_chien_ctrl #(
  parameter int unsigned SYMB_WIDTH      = 8,
  parameter int unsigned ROOTS_PER_CYCLE = 4,
  parameter int unsigned CYCLES_NUM      = 64,
  parameter int unsigned N_LEN           = 255,
  parameter int unsigned T_MAX           = 8,
  localparam int unsigned DW = $clog2(T_MAX + 1),
  localparam int unsigned CW = $clog2(T_MAX + 2)
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       job_vld,
  output logic                       job_rdy,
  input  logic [DW-1:0]              job_deg,
  output logic                       gen_start,
  input  logic                       eval_vld,
  input  logic [ROOTS_PER_CYCLE-1:0] eval_zero,
  output logic                       pos_vld,
  output logic [SYMB_WIDTH-1:0]      pos_base,
  output logic [ROOTS_PER_CYCLE-1:0] pos_mask,
  output logic                       done_vld,
  input  logic                       done_rdy,
  output logic [CW-1:0]              done_cnt,
  output logic                       done_fail
);

  localparam int unsigned BW  = (CYCLES_NUM > 1) ? $clog2(CYCLES_NUM) : 1;
  localparam int unsigned PW  = SYMB_WIDTH + 1;
  localparam int unsigned PCW = $clog2(ROOTS_PER_CYCLE + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(CYCLES_NUM - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_SCAN  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic [DW-1:0]              deg_q, deg_d;
  logic [BW-1:0]              beat_q, beat_d;
  logic [CW-1:0]              root_q, root_d;
  logic                       pos_vld_q, pos_vld_d;
  logic [SYMB_WIDTH-1:0]      pos_base_q, pos_base_d;
  logic [ROOTS_PER_CYCLE-1:0] pos_mask_q, pos_mask_d;

  logic [PW-1:0]              base_ext;
  logic [ROOTS_PER_CYCLE-1:0] lane_mask;
  logic [PCW-1:0]             hits;
  logic [CW:0]                root_sum;
  logic                       beat_fire;

  // Lane positions use one extra bit so base+i past 2^SYMB_WIDTH-1 is still seen as pad.
  always_comb begin
    base_ext  = PW'(beat_q) * PW'(ROOTS_PER_CYCLE);
    lane_mask = '0;
    hits      = '0;
    for (int unsigned i = 0; i < ROOTS_PER_CYCLE; i++) begin
      if ((base_ext + PW'(i)) < PW'(N_LEN)) lane_mask[i] = eval_zero[i];
    end
    for (int unsigned i = 0; i < ROOTS_PER_CYCLE; i++) begin
      hits = hits + PCW'(lane_mask[i]);
    end
    beat_fire = eval_vld && (state_q == S_SCAN);
    root_sum  = {1'b0, root_q} + (CW+1)'(hits);
  end

  always_comb begin
    state_d    = state_q;
    deg_d      = deg_q;
    beat_d     = beat_q;
    root_d     = root_q;
    pos_vld_d  = beat_fire;
    pos_base_d = beat_fire ? base_ext[SYMB_WIDTH-1:0] : '0;
    pos_mask_d = beat_fire ? lane_mask : '0;
    case (state_q)
      S_IDLE: begin
        if (job_vld) begin
          deg_d  = job_deg;
          root_d = '0;
          if ((job_deg == '0) || (job_deg > DW'(T_MAX))) state_d = S_DONE;
          else                                           state_d = S_START;
        end
      end
      S_START: begin
        beat_d  = '0;
        root_d  = '0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (beat_fire) begin
          beat_d = beat_q + BW'(1);
          root_d = (root_sum > {1'b0, {CW{1'b1}}}) ? '1 : root_sum[CW-1:0];
          if (beat_q == LAST_BEAT) state_d = S_DONE;
        end
      end
      default: begin
        if (done_rdy) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      deg_q      <= '0;
      beat_q     <= '0;
      root_q     <= '0;
      pos_vld_q  <= 1'b0;
      pos_base_q <= '0;
      pos_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      deg_q      <= deg_d;
      beat_q     <= beat_d;
      root_q     <= root_d;
      pos_vld_q  <= pos_vld_d;
      pos_base_q <= pos_base_d;
      pos_mask_q <= pos_mask_d;
    end
  end

  // A saturated count exceeds T_MAX >= deg, so it always reads as a mismatch.
  assign job_rdy   = (state_q == S_IDLE);
  assign gen_start = (state_q == S_START);
  assign done_vld  = (state_q == S_DONE);
  assign done_cnt  = done_vld ? root_q : '0;
  assign done_fail = done_vld && ((root_q != CW'(deg_q)) || (deg_q > DW'(T_MAX)));
  assign pos_vld   = pos_vld_q;
  assign pos_base  = pos_base_q;
  assign pos_mask  = pos_mask_q;

endmodule
